// File: rtl/shift_pkg.sv
// shift_pkg: shared types and widths for the shift_sched round-robin shifter scheduler.
// Optional rsp_flags output is enabled by defining SHIFT_SCHED_FLAGS_EN.
package shift_pkg;
    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    typedef enum logic [1:0] {
        SLL     = 2'd0,
        SRA     = 2'd1,
        ROR     = 2'd2,
        ILLEGAL = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;
endpackage

// File: rtl/shift_sched_if.sv
// shift_sched_if: request/response bundle between the requesters and the scheduler.
// The rsp_flags signal exists only when SHIFT_SCHED_FLAGS_EN is defined.
interface shift_sched_if import shift_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ*AMT_W-1:0]  req_amt;
    logic [NUM_REQ*2-1:0]      req_mode;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;
    logic                      rsp_err;
`ifdef SHIFT_SCHED_FLAGS_EN
    logic [2:0]                rsp_flags;

    modport master (
        output req_valid, req_data, req_amt, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, rsp_flags
    );
    modport slave (
        input  req_valid, req_data, req_amt, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err, rsp_flags
    );
`else
    modport master (
        output req_valid, req_data, req_amt, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
    modport slave (
        input  req_valid, req_data, req_amt, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
    );
`endif
endinterface

// File: rtl/shift_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr_i upward modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any_o && req_i[(int'(ptr_i) + i) % NUM_REQ]) begin
                any_o = 1'b1;
                idx_o = ID_W'((int'(ptr_i) + i) % NUM_REQ);
            end
        end
    end

    assign gnt_o = any_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/shift_sched_shifter.sv
// shifter: 16-bit barrel shifter with SLL, SRA and ROR; mode 3 passes the operand through.
module shifter import shift_pkg::*; (
    input  logic [DATA_W-1:0] data_i,
    input  logic [AMT_W-1:0]  amt_i,
    input  mode_e             mode_i,
    output logic [DATA_W-1:0] res_o
);
    logic [2*DATA_W-1:0] rot;
    logic signed [DATA_W-1:0] sra;

    assign rot = {data_i, data_i} >> amt_i;
    assign sra = $signed(data_i) >>> amt_i;
    assign res_o = mode_i == SLL ? data_i << amt_i :
                   mode_i == SRA ? sra :
                   mode_i == ROR ? rot[DATA_W-1:0] : data_i;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler sharing one barrel shifter among NUM_REQ requesters.
// Define SHIFT_SCHED_FLAGS_EN to add the registered rsp_flags = {carry, negative, zero}.
module shift_sched import shift_pkg::*; #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input logic          clk,
    input logic          rst_n,
    shift_sched_if.slave bus
);
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic [ID_W-1:0]    ptr_d;
    logic [DATA_W-1:0]  sh_res;
    logic [DATA_W-1:0]  res_d;

    state_e             state_q;
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    id_q;
    logic [DATA_W-1:0]  data_q;
    logic [AMT_W-1:0]   amt_q;
    mode_e              mode_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_data_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic               rsp_err_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    shifter u_shift (
        .data_i (data_q),
        .amt_i  (amt_q),
        .mode_i (mode_q),
        .res_o  (sh_res)
    );

    // Grants are offered only while idle and out of reset.
    assign bus.req_ready = (rst_n && state_q == IDLE) ? gnt : '0;
    assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign res_d = (mode_q == ILLEGAL) ? data_q : sh_res;

`ifdef SHIFT_SCHED_FLAGS_EN
    logic       carry_d;
    logic [2:0] flags_q;

    assign carry_d = (amt_q == '0 || mode_q == ILLEGAL) ? 1'b0 :
                     mode_q == SLL ? data_q[4'd0 - amt_q] :
                     mode_q == SRA ? data_q[amt_q - 4'd1] : sh_res[DATA_W-1];
    assign bus.rsp_flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) flags_q <= '0;
        else if (state_q == EXEC) flags_q <= {carry_d, res_d[DATA_W-1], res_d == '0};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            data_q      <= '0;
            amt_q       <= '0;
            mode_q      <= SLL;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (gnt_any) begin
                    data_q   <= bus.req_data[gnt_idx*DATA_W +: DATA_W];
                    amt_q    <= bus.req_amt[gnt_idx*AMT_W +: AMT_W];
                    mode_q   <= mode_e'(bus.req_mode[gnt_idx*2 +: 2]);
                    id_q     <= gnt_idx;
                    rr_ptr_q <= ptr_d;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    rsp_data_q  <= res_d;
                    rsp_err_q   <= mode_q == ILLEGAL;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: vector table, directed corner sequences and a randomized scoreboard for shift_sched.
module tb_shift_sched;
    import shift_pkg::*;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_sched_if #(.NUM_REQ(NR)) bus();
    shift_sched #(.NUM_REQ(NR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [15:0] d;
        int          a;
        int          m;
        logic [15:0] r;
        logic        e;
        logic [2:0]  f;
    } vec_t;
    vec_t vt[11];

    bit          pend[NR];
    logic [15:0] pd[NR];
    int          pa[NR];
    int          pm[NR];
    int          ptr = 0;
    int          cyc = 0;
    int          acc = 0;
    bit          busy = 0;
    logic [15:0] e_d;
    int          e_id;
    logic        e_e;
    logic [2:0]  e_f;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int a, input int m);
        logic [15:0] r;
        for (int i = 0; i < 16; i++)
            r[i] = (m == 0) ? ((i >= a) ? d[i-a] : 1'b0) :
                   (m == 1) ? ((i + a < 16) ? d[i+a] : d[15]) :
                   (m == 2) ? d[(i+a)%16] : d[i];
        return r;
    endfunction

    function automatic logic [2:0] ref_flags(input logic [15:0] d, input int a, input int m);
        logic [15:0] r;
        logic c;
        r = ref_shift(d, a, m);
        c = (a == 0 || m == 3) ? 1'b0 : (m == 0) ? d[16-a] : (m == 1) ? d[a-1] : r[15];
        return {c, r[15], r == 16'h0};
    endfunction

    task automatic put(input int r, input logic [15:0] d, input int a, input int m);
        bus.req_data[16*r +: 16] = d;
        bus.req_amt[4*r +: 4]    = 4'(a);
        bus.req_mode[2*r +: 2]   = 2'(m);
    endtask

    task automatic chk_rsp(input string n, input logic [15:0] d, input int id, input logic e, input logic [2:0] f);
        chk({n, "_valid"}, bus.rsp_valid, 1);
        chk({n, "_data"}, bus.rsp_data, d);
        chk({n, "_id"}, bus.rsp_id, id);
        chk({n, "_err"}, bus.rsp_err, e);
`ifdef SHIFT_SCHED_FLAGS_EN
        chk({n, "_flags"}, bus.rsp_flags, f);
`else
        if (f === 3'bx) $display("unused flags");
`endif
    endtask

    task automatic run_op(input int r, input vec_t v, input string n);
        int k = 0;
        @(negedge clk);
        put(r, v.d, v.a, v.m);
        bus.req_valid = NR'(1) << r;
        bus.rsp_ready = 1'b1;
        #1;
        while (bus.req_ready !== (NR'(1) << r) && k < 10) begin
            k++;
            @(negedge clk); #1;
        end
        chk({n, "_grant"}, bus.req_ready, NR'(1) << r);
        ptr = (r + 1) % NR;
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk({n, "_exec"}, bus.rsp_valid, 0);
        @(negedge clk); #1;
        chk_rsp(n, v.r, r, v.e, v.f);
        @(negedge clk); #1;
        chk({n, "_done"}, bus.rsp_valid, 0);
    endtask

    function automatic int pick();
        for (int k = 0; k < NR; k++)
            if (pend[(ptr + k) % NR]) return (ptr + k) % NR;
        return -1;
    endfunction

    // Cycle-level scoreboard: a single outstanding op, response due two cycles after accept.
    task automatic run(input int cycles, input int gen_pct, input int rdy_pct, input bit fair);
        int prev = -1;
        int ngr = 0;
        int g;
        bit ev;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cyc++;
            for (int i = 0; i < NR; i++) begin
                if (!pend[i] && $urandom_range(99) < gen_pct) begin
                    pend[i] = 1'b1;
                    pd[i] = 16'($urandom);
                    pa[i] = $urandom_range(15);
                    pm[i] = $urandom_range(3);
                end
                bus.req_valid[i] = pend[i];
                put(i, pd[i], pa[i], pm[i]);
            end
            bus.rsp_ready = $urandom_range(99) < rdy_pct;
            #1;
            g = busy ? -1 : pick();
            chk("rr_ready", bus.req_ready, (g >= 0) ? NR'(1) << g : '0);
            ev = busy && (cyc - acc >= 2);
            chk("rr_rsp_valid", bus.rsp_valid, ev);
            if (ev) begin
                chk_rsp("rr", e_d, e_id, e_e, e_f);
                if (bus.rsp_ready) busy = 1'b0;
            end
            if (g >= 0) begin
                busy = 1'b1;
                acc = cyc;
                e_d = ref_shift(pd[g], pa[g], pm[g]);
                e_f = ref_flags(pd[g], pa[g], pm[g]);
                e_e = pm[g] == 3;
                e_id = g;
                ptr = (g + 1) % NR;
                pend[g] = 1'b0;
                if (fair && prev >= 0) chk("fair_alt", g, (prev + 1) % NR);
                prev = g;
                ngr++;
            end
        end
        if (fair) chk("fair_count", ngr >= 4, 1);
    endtask

    initial begin
        vt[0]  = '{16'h8001, 1,  0, 16'h0002, 1'b0, 3'b100};
        vt[1]  = '{16'h8000, 4,  1, 16'hF800, 1'b0, 3'b010};
        vt[2]  = '{16'h000F, 4,  2, 16'hF000, 1'b0, 3'b110};
        vt[3]  = '{16'h1234, 0,  0, 16'h1234, 1'b0, 3'b000};
        vt[4]  = '{16'h8765, 0,  1, 16'h8765, 1'b0, 3'b010};
        vt[5]  = '{16'h0000, 0,  2, 16'h0000, 1'b0, 3'b001};
        vt[6]  = '{16'h1234, 5,  3, 16'h1234, 1'b1, 3'b000};
        vt[7]  = '{16'h0001, 15, 0, 16'h8000, 1'b0, 3'b010};
        vt[8]  = '{16'h8000, 15, 1, 16'hFFFF, 1'b0, 3'b010};
        vt[9]  = '{16'h0001, 15, 2, 16'h0002, 1'b0, 3'b000};
        vt[10] = '{16'h8000, 1,  0, 16'h0000, 1'b0, 3'b101};
        for (int i = 0; i < NR; i++) begin
            pend[i] = 1'b0; pd[i] = '0; pa[i] = 0; pm[i] = 0;
        end
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_mode  = '0;
        bus.rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        bus.req_valid = '1;
        #1;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_id", bus.rsp_id, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
`ifdef SHIFT_SCHED_FLAGS_EN
        chk("rst_rsp_flags", bus.rsp_flags, 0);
`endif
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) run_op(i % NR, vt[i], $sformatf("vec%0d", i));

        // Backpressure: response held five cycles while requester 0 waits.
        @(negedge clk);
        put(1, 16'h00F0, 4, 0);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_grant1", bus.req_ready, 2'b10);
        @(negedge clk);
        put(0, 16'hA5A5, 1, 2);
        bus.req_valid = 2'b01;
        #1;
        chk("bp_exec_ready", bus.req_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            chk_rsp("bp_hold", 16'h0F00, 1, 1'b0, 3'b000);
            chk("bp_hold_ready", bus.req_ready, 0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", bus.rsp_valid, 1);
        chk("bp_hs_ready", bus.req_ready, 0);
        @(negedge clk); #1;
        chk("bp_after_valid", bus.rsp_valid, 0);
        chk("bp_next_grant", bus.req_ready, 2'b01);
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); #1;
        chk_rsp("bp_second", 16'hD2D2, 0, 1'b0, 3'b110);
        @(negedge clk); #1;
        chk("bp_idle", bus.rsp_valid, 0);

        // Reset in EXEC discards the op and clears the pointer.
        @(negedge clk);
        put(0, 16'hFFFF, 3, 0);
        bus.req_valid = 2'b01;
        #1;
        chk("rx_grant", bus.req_ready, 2'b01);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #1;
        chk("rx_rsp_valid", bus.rsp_valid, 0);
        chk("rx_req_ready", bus.req_ready, 0);
        @(negedge clk);
        bus.req_valid = '0;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("rx_no_rsp", bus.rsp_valid, 0);
        end
        @(negedge clk);
        put(0, 16'h8000, 1, 0);
        put(1, 16'h5555, 2, 1);
        bus.req_valid = 2'b11;
        #1;
        chk("rx_ptr0_grant", bus.req_ready, 2'b01);
        ptr = 1;
        @(negedge clk);
        bus.req_valid = '0;
        @(negedge clk); #1;
        chk_rsp("rx_flags", 16'h0000, 0, 1'b0, 3'b101);
        @(negedge clk);

        run(12, 100, 100, 1'b1);
        run(30, 0, 100, 1'b0);
        chk("fair_drained", {busy, pend[0], pend[1]}, 0);
        run(2000, 40, 60, 1'b0);
        run(30, 0, 100, 1'b0);
        chk("rand_drained", {busy, pend[0], pend[1]}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
